// File: rtl/hans_speicher_pkg.sv
// hans_speicher_pkg: shared state/access types and default sizing for the memory arbiter.
package hans_speicher_pkg;
  localparam int STANDARD_ADRESS_BREITE = 24;
  localparam int STANDARD_TIMEOUT = 255;
  typedef enum logic [2:0] {LEERLAUF, INSTR_LESEN, DATEN_LESEN, DATEN_SCHREIBEN, FERTIG} zustand_t;
  typedef enum logic [1:0] {INSTR, LESEN, SCHREIBEN} zugriff_t;
endpackage

// File: rtl/warte_zaehler.sv
// warte_zaehler: clearable wait counter; ende flags the last wait cycle before TIMEOUT expires.
module warte_zaehler #(
  parameter int TIMEOUT = 255
) (
  input  logic Clock,
  input  logic Reset,
  input  logic loeschen,
  input  logic zaehlen,
  output logic ende
);
  localparam int BREITE = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [BREITE-1:0] stand;
  always_ff @(posedge Clock)
    if (Reset || loeschen) stand <= '0;
    else if (zaehlen) stand <= stand + 1'b1;
  assign ende = TIMEOUT != 0 && stand == BREITE'(TIMEOUT - 1);
endmodule

// File: rtl/speicher_arbiter.sv
// speicher_arbiter: merges instruction fetch and data load/store onto one single-port memory bus,
// one access at a time with data-over-instruction priority and a sticky bus timeout flag.
module speicher_arbiter
  import hans_speicher_pkg::*;
#(
  parameter int ADRESS_BREITE = STANDARD_ADRESS_BREITE,
  parameter int TIMEOUT = STANDARD_TIMEOUT
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              InstruktionAdresse,
  input  logic                     LeseInstruktion,
  output logic [31:0]              Instruktion,
  output logic                     InstruktionGeladen,
  input  logic [31:0]              DatenAdresse,
  input  logic [31:0]              DatenRaus,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  output logic [31:0]              DatenRein,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [31:0]              SpeicherSchreibDaten,
  output logic                     SpeicherLesen,
  output logic                     SpeicherSchreiben,
  input  logic [31:0]              SpeicherLeseDaten,
  input  logic                     SpeicherBereit,
  output logic                     Busfehler
);
  zustand_t zustand, naechsterZustand;
  zugriff_t art, naechsteArt;
  logic zugriff, zaehlerEnde, abschluss, unusedBits;
  logic [31:0] ergebnis;
  assign unusedBits = ^{InstruktionAdresse[31:ADRESS_BREITE], DatenAdresse[31:ADRESS_BREITE]};
  assign zugriff = zustand == INSTR_LESEN || zustand == DATEN_LESEN || zustand == DATEN_SCHREIBEN;
  assign abschluss = zugriff && (SpeicherBereit || zaehlerEnde);
  // a timed-out read returns zero
  assign ergebnis = SpeicherBereit ? SpeicherLeseDaten : '0;
  warte_zaehler #(.TIMEOUT(TIMEOUT)) zaehler (
    .Clock(Clock),
    .Reset(Reset),
    .loeschen(zustand == LEERLAUF),
    .zaehlen(zugriff && !SpeicherBereit),
    .ende(zaehlerEnde)
  );
  always_comb begin
    naechsteArt = SchreibeDaten ? SCHREIBEN : LeseDaten ? LESEN : INSTR;
    naechsterZustand = zustand;
    if (zustand == LEERLAUF)
      naechsterZustand = SchreibeDaten ? DATEN_SCHREIBEN : LeseDaten ? DATEN_LESEN :
                         LeseInstruktion ? INSTR_LESEN : LEERLAUF;
    else if (zustand == FERTIG) naechsterZustand = LEERLAUF;
    else if (abschluss) naechsterZustand = FERTIG;
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand <= LEERLAUF;
      art <= INSTR;
      SpeicherAdresse <= '0;
      SpeicherSchreibDaten <= '0;
      Instruktion <= '0;
      DatenRein <= '0;
      Busfehler <= 1'b0;
    end else begin
      zustand <= naechsterZustand;
      if (zustand == LEERLAUF) begin
        art <= naechsteArt;
        SpeicherAdresse <= (SchreibeDaten || LeseDaten) ? DatenAdresse[ADRESS_BREITE-1:0]
                                                        : InstruktionAdresse[ADRESS_BREITE-1:0];
        if (SchreibeDaten) SpeicherSchreibDaten <= DatenRaus;
      end
      if (abschluss) begin
        if (art == INSTR) Instruktion <= ergebnis;
        if (art == LESEN) DatenRein <= ergebnis;
        if (!SpeicherBereit) Busfehler <= 1'b1;
      end
    end
  end
  assign SpeicherLesen = zustand == INSTR_LESEN || zustand == DATEN_LESEN;
  assign SpeicherSchreiben = zustand == DATEN_SCHREIBEN;
  assign InstruktionGeladen = zustand == FERTIG && art == INSTR;
  assign DatenGeladen = zustand == FERTIG && art == LESEN;
  assign DatenGespeichert = zustand == FERTIG && art == SCHREIBEN;
endmodule

// File: tb/tb_speicher_arbiter.sv
// tb_speicher_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_speicher_arbiter;
  localparam int TO = 4;
  logic Clock = 0, Reset = 1;
  logic [31:0] InstruktionAdresse = 0, DatenAdresse = 0, DatenRaus = 0, SpeicherLeseDaten = 0;
  logic LeseInstruktion = 0, LeseDaten = 0, SchreibeDaten = 0, SpeicherBereit = 0;
  logic [31:0] Instruktion, DatenRein, SpeicherSchreibDaten;
  logic [23:0] SpeicherAdresse;
  logic InstruktionGeladen, DatenGeladen, DatenGespeichert, SpeicherLesen, SpeicherSchreiben, Busfehler;

  speicher_arbiter #(.ADRESS_BREITE(24), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstruktionAdresse(InstruktionAdresse), .LeseInstruktion(LeseInstruktion),
    .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
    .DatenAdresse(DatenAdresse), .DatenRaus(DatenRaus), .LeseDaten(LeseDaten),
    .SchreibeDaten(SchreibeDaten), .DatenRein(DatenRein), .DatenGeladen(DatenGeladen),
    .DatenGespeichert(DatenGespeichert), .SpeicherAdresse(SpeicherAdresse),
    .SpeicherSchreibDaten(SpeicherSchreibDaten), .SpeicherLesen(SpeicherLesen),
    .SpeicherSchreiben(SpeicherSchreiben), .SpeicherLeseDaten(SpeicherLeseDaten),
    .SpeicherBereit(SpeicherBereit), .Busfehler(Busfehler)
  );

  always #5 Clock = ~Clock;

  int tests = 0, fails = 0;
  function automatic void chk(string name, logic [31:0] ist, logic [31:0] soll);
    tests++;
    if (ist !== soll) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, ist, soll);
    end
  endfunction

  // transaction model: kind 0 = fetch, 1 = load, 2 = store
  bit mBusy = 0, mFertig = 0, mErr = 0;
  int mArt = 0, mAlter = 0;
  logic [23:0] mAdr = 0;
  logic [31:0] mDaten = 0, mInstr = 0, mRein = 0;

  function automatic void beende(logic [31:0] wert, bit fehler);
    mBusy = 0;
    mFertig = 1;
    if (mArt == 0) mInstr = wert;
    if (mArt == 1) mRein = wert;
    if (fehler) mErr = 1;
  endfunction

  always @(posedge Clock) begin
    if (Reset) begin
      mBusy = 0; mFertig = 0; mErr = 0; mInstr = 0; mRein = 0;
    end else if (mFertig) mFertig = 0;
    else if (mBusy) begin
      mAlter++;
      if (SpeicherBereit) beende(SpeicherLeseDaten, 0);
      else if (mAlter == TO) beende(32'h0, 1);
    end else if (SchreibeDaten || LeseDaten || LeseInstruktion) begin
      mBusy = 1;
      mAlter = 0;
      mArt = SchreibeDaten ? 2 : LeseDaten ? 1 : 0;
      mAdr = mArt == 0 ? InstruktionAdresse[23:0] : DatenAdresse[23:0];
      mDaten = DatenRaus;
    end
  end

  int zyklusNr = 0, nLesen = 0, nSchreiben = 0, nIG = 0, nDG = 0, nDS = 0;
  int letzterDG = 0, letzterIG = 0, abstandDG = 0;
  always @(posedge Clock) begin
    #1;
    zyklusNr++;
    chk("SpeicherLesen", SpeicherLesen, mBusy && mArt != 2);
    chk("SpeicherSchreiben", SpeicherSchreiben, mBusy && mArt == 2);
    chk("InstruktionGeladen", InstruktionGeladen, mFertig && mArt == 0);
    chk("DatenGeladen", DatenGeladen, mFertig && mArt == 1);
    chk("DatenGespeichert", DatenGespeichert, mFertig && mArt == 2);
    chk("Instruktion", Instruktion, mInstr);
    chk("DatenRein", DatenRein, mRein);
    chk("Busfehler", Busfehler, mErr);
    if (mBusy) chk("SpeicherAdresse", SpeicherAdresse, mAdr);
    if (mBusy && mArt == 2) chk("SpeicherSchreibDaten", SpeicherSchreibDaten, mDaten);
    if (SpeicherLesen) nLesen++;
    if (SpeicherSchreiben) nSchreiben++;
    if (InstruktionGeladen) begin nIG++; letzterIG = zyklusNr; end
    if (DatenGespeichert) nDS++;
    if (DatenGeladen) begin nDG++; abstandDG = zyklusNr - letzterDG; letzterDG = zyklusNr; end
  end

  // bench-side memory and requesters
  int wartezeit = 0, strobeZyklen = 0, ladeWiederholungen = 0;
  bit zufall = 0;
  task automatic zyklus();
    @(negedge Clock);
    if (SpeicherLesen || SpeicherSchreiben) begin
      strobeZyklen++;
      SpeicherBereit = strobeZyklen > wartezeit;
    end else begin
      strobeZyklen = 0;
      if (zufall) wartezeit = $urandom_range(0, 5);
      SpeicherBereit = 1'($urandom_range(0, 1));
    end
    SpeicherLeseDaten = $urandom;
    if (InstruktionGeladen) LeseInstruktion = 0;
    if (DatenGespeichert) SchreibeDaten = 0;
    if (DatenGeladen) begin
      if (ladeWiederholungen > 0) ladeWiederholungen--;
      else LeseDaten = 0;
    end
  endtask

  task automatic abarbeiten(input string name, input int budget);
    int n = 0;
    do begin zyklus(); n++; end
    while ((LeseInstruktion || LeseDaten || SchreibeDaten) && n < budget);
    chk(name, n < budget, 1);
    zyklus();
  endtask

  task automatic zaehlerNull();
    nLesen = 0; nSchreiben = 0; nIG = 0; nDG = 0; nDS = 0;
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    chk("reset_lesen", SpeicherLesen, 0);
    chk("reset_schreiben", SpeicherSchreiben, 0);
    chk("reset_adresse", SpeicherAdresse, 0);
    chk("reset_pulse", {InstruktionGeladen, DatenGeladen, DatenGespeichert}, 0);
    chk("reset_busfehler", Busfehler, 0);
    Reset = 0;
    InstruktionAdresse = 32'h10; LeseInstruktion = 1;
    SpeicherBereit = 1; SpeicherLeseDaten = 32'h12345678;
    @(negedge Clock);
    chk("fetch_strobe", SpeicherLesen, 1);
    chk("fetch_adresse", SpeicherAdresse, 24'h10);
    @(negedge Clock);
    chk("fetch_puls", InstruktionGeladen, 1);
    chk("fetch_daten", Instruktion, 32'h12345678);
    LeseInstruktion = 0;
    @(negedge Clock);
    chk("fetch_leer", {SpeicherLesen, InstruktionGeladen}, 0);
    zaehlerNull();
    wartezeit = 3; DatenAdresse = 32'h40; DatenRaus = 32'hCAFEBABE; SchreibeDaten = 1;
    abarbeiten("store_budget", 20);
    chk("store_strobes", nSchreiben, 4);
    chk("store_pulse", nDS, 1);
    zaehlerNull();
    wartezeit = 1; InstruktionAdresse = 32'h200; DatenAdresse = 32'h300;
    LeseInstruktion = 1; LeseDaten = 1;
    abarbeiten("prio_budget", 30);
    chk("prio_dg", nDG, 1);
    chk("prio_ig", nIG, 1);
    chk("prio_reihenfolge", letzterDG < letzterIG, 1);
    zaehlerNull();
    wartezeit = 100; DatenAdresse = 32'h80; LeseDaten = 1;
    abarbeiten("timeout_budget", 20);
    chk("timeout_strobes", nLesen, 4);
    chk("timeout_puls", nDG, 1);
    chk("timeout_daten", DatenRein, 0);
    chk("timeout_busfehler", Busfehler, 1);
    zaehlerNull();
    wartezeit = 0; ladeWiederholungen = 1; DatenAdresse = 32'h90; LeseDaten = 1;
    abarbeiten("rueckrueck_budget", 20);
    chk("rueckrueck_anzahl", nDG, 2);
    chk("rueckrueck_abstand", abstandDG, 3);
    chk("busfehler_klebt", Busfehler, 1);
    zaehlerNull();
    InstruktionAdresse = 32'h500; LeseInstruktion = 1; SpeicherBereit = 0;
    @(negedge Clock);
    @(negedge Clock);
    chk("abbruch_strobe_vorher", SpeicherLesen, 1);
    Reset = 1; LeseInstruktion = 0;
    @(negedge Clock);
    Reset = 0;
    chk("abbruch_strobe", SpeicherLesen, 0);
    chk("abbruch_busfehler", Busfehler, 0);
    chk("abbruch_daten", Instruktion | DatenRein, 0);
    @(negedge Clock);
    chk("abbruch_kein_puls", nIG, 0);
    zufall = 1;
    for (int i = 0; i < 4000; i++) begin
      zyklus();
      Reset = $urandom_range(0, 599) == 0;
      if (Reset) begin
        LeseInstruktion = 0; LeseDaten = 0; SchreibeDaten = 0;
      end else begin
        if (!LeseInstruktion && $urandom_range(0, 2) == 0) begin
          LeseInstruktion = 1; InstruktionAdresse = $urandom;
        end
        if (!LeseDaten && !SchreibeDaten) begin
          case ($urandom_range(0, 5))
            0: LeseDaten = 1;
            1: SchreibeDaten = 1;
            2: begin LeseDaten = 1; SchreibeDaten = 1; end
            default: ;
          endcase
          DatenAdresse = $urandom; DatenRaus = $urandom;
        end
      end
    end
    @(negedge Clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
